// File: rtl/serial_port_ctrl.sv
// rtl/serial_port_ctrl.sv - memory-mapped 8N1 UART at 0xBF00 (data) / 0xBF01 (status)
// Optional 4-entry receive FIFO when SERIAL_RX_FIFO_EN is defined; otherwise a single holding register.
module serial_port_ctrl #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        write_en,
    input  logic        read_en,
    input  logic        rxd,
    output logic        txd,
    output logic [7:0]  serialPortData,
    output logic [1:0]  serialPortState
);

    localparam logic [15:0] DATA_ADDR = 16'hBF00;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[15:8];

    logic tx_store;
    logic pop_req;
    assign tx_store = write_en && (addr == DATA_ADDR);
    assign pop_req  = read_en && (addr == DATA_ADDR);

    uart_state_e tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_byte_q;
    logic        txd_q;
    logic        tx_ready_q;
    logic        tx_line;

    // Line level implied by the current state; registered into txd_q, so txd lags the FSM by one cycle.
    always_comb begin
        tx_line = 1'b1;
        case (tx_state_q)
            START:   tx_line = 1'b0;
            DATA:    tx_line = tx_byte_q[tx_bit_q];
            default: tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            txd_q      <= tx_line;
            tx_ready_q <= (tx_state_q == IDLE);
            case (tx_state_q)
                IDLE: begin
                    if (tx_store) begin
                        tx_byte_q  <= wdata[7:0];
                        tx_cnt_q   <= '0;
                        tx_state_q <= START;
                    end
                end
                START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) tx_state_q <= STOP;
                        else                  tx_bit_q   <= tx_bit_q + 3'd1;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign txd = txd_q;

    uart_state_e rx_state_q;
    logic        rx_meta_q;
    logic        rx_sync_q;
    logic        rx_prev_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q <= rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            case (rx_state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= START;
                    end
                end
                START: begin
                    // Mid start bit: a line already back high was only a glitch.
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign rx_push = (rx_state_q == STOP) && (rx_cnt_q == BIT_LAST) && rx_sync_q;

    logic       buf_valid;
    logic [7:0] buf_head;
    logic       pop;

`ifdef SERIAL_RX_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic       push_ok;

    assign buf_valid = (count_q != 3'd0);
    assign buf_head  = fifo_q[rd_ptr_q];
    assign pop       = pop_req && buf_valid;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign push_ok   = rx_push && ((count_q != 3'd4) || pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= rx_shift_q;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_d;
        end
    end
`else
    logic [7:0] hold_q;
    logic       hold_valid_q;

    assign buf_valid = hold_valid_q;
    assign buf_head  = hold_q;
    assign pop       = pop_req && hold_valid_q;

    // Newest byte wins: a push overrides both a stale byte and a same-cycle pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (rx_push) begin
            hold_q       <= rx_shift_q;
            hold_valid_q <= 1'b1;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    assign serialPortData  = buf_valid ? buf_head : 8'h00;
    assign serialPortState = {buf_valid, tx_ready_q};

endmodule
